// File: rtl/mem_stage_if.sv
// Data-memory / bridge port of the MEM stage.
// master drives address, data, byte enables and strobe; slave returns read data.
interface mem_stage_if;
  logic [31:0] DM_Addr;
  logic [31:0] DM_WData;
  logic [3:0]  DM_BE;
  logic        DM_WE;
  logic [31:0] DM_RData;

  modport master (
    output DM_Addr, DM_WData, DM_BE, DM_WE,
    input  DM_RData
  );

  modport slave (
    input  DM_Addr, DM_WData, DM_BE, DM_WE,
    output DM_RData
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, DM write port, address exceptions, load extension.
// Ports: clk/reset/flush/stall, *_EX inputs, *_MEM outputs, dm bus (master).
module mem_stage #(
  parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] Instr_EX,
  input  logic [31:0] PC_EX,
  input  logic [31:0] ALUout_EX,
  input  logic        Overflow_EX,
  input  logic [4:0]  RegA3_EX,
  input  logic [31:0] ForwardToDM_EX,
  input  logic [4:0]  ExcCode_EX,
  output logic [31:0] Instr_MEM,
  output logic [31:0] PC_MEM,
  output logic [31:0] ALUout_MEM,
  output logic [4:0]  RegA3_MEM,
  output logic [31:0] LoadData_MEM,
  output logic [4:0]  ExcCode_MEM,
  mem_stage_if.master dm
);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  exc_q, exc_d;

  logic [5:0] op_ex;
  logic       ex_ld, ex_st;
  logic [4:0] exc_cap;

  assign op_ex = Instr_EX[31:26];
  assign ex_ld = op_ex == OP_LW || op_ex == OP_LB || op_ex == OP_LBU
              || op_ex == OP_LH || op_ex == OP_LHU;
  assign ex_st = op_ex == OP_SW || op_ex == OP_SB || op_ex == OP_SH;

  // Address-overflow on a memory op becomes an address error.
  always_comb begin
    exc_cap = ExcCode_EX;
    if (Overflow_EX && ex_ld) exc_cap = EXC_ADEL;
    else if (Overflow_EX && ex_st) exc_cap = EXC_ADES;
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    a3_d    = a3_q;
    data_d  = data_q;
    exc_d   = exc_q;
    if (flush) begin
      instr_d = '0;
      pc_d    = '0;
      alu_d   = '0;
      a3_d    = '0;
      data_d  = '0;
      exc_d   = '0;
    end else if (!stall) begin
      instr_d = Instr_EX;
      pc_d    = PC_EX;
      alu_d   = ALUout_EX;
      a3_d    = RegA3_EX;
      data_d  = ForwardToDM_EX;
      exc_d   = exc_cap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      a3_q    <= '0;
      data_q  <= '0;
      exc_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      a3_q    <= a3_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  assign Instr_MEM  = instr_q;
  assign PC_MEM     = pc_q;
  assign ALUout_MEM = alu_q;
  assign RegA3_MEM  = a3_q;

  logic [5:0]  op;
  logic [31:0] a;
  logic is_lw, is_lb, is_lbu, is_lh, is_lhu;
  logic is_sw, is_sb, is_sh;
  logic is_ld, is_st, is_word, is_half;

  assign op     = instr_q[31:26];
  assign a      = alu_q;
  assign is_lw  = op == OP_LW;
  assign is_lb  = op == OP_LB;
  assign is_lbu = op == OP_LBU;
  assign is_lh  = op == OP_LH;
  assign is_lhu = op == OP_LHU;
  assign is_sw  = op == OP_SW;
  assign is_sb  = op == OP_SB;
  assign is_sh  = op == OP_SH;
  assign is_ld  = is_lw | is_lb | is_lbu | is_lh | is_lhu;
  assign is_st  = is_sw | is_sb | is_sh;
  assign is_word = is_lw | is_sw;
  assign is_half = is_lh | is_lhu | is_sh;

  logic in_dm, in_tc, tc_cnt, misal, addr_err;

  assign in_dm = a <= DM_TOP;
  assign in_tc = (a >= TC0_BASE && a < TC0_BASE + 32'd12)
              || (a >= TC1_BASE && a < TC1_BASE + 32'd12);
  // Offset 8 of each timer is the read-only count register.
  assign tc_cnt = a == TC0_BASE + 32'd8 || a == TC1_BASE + 32'd8;
  assign misal  = (is_word && a[1:0] != 2'b00) || (is_half && a[0]);

  assign addr_err = (is_ld | is_st)
                 && (misal || !(in_dm || in_tc)
                     || (in_tc && !is_word)
                     || (is_st && tc_cnt));

  always_comb begin
    ExcCode_MEM = exc_q;
    if (exc_q == 5'd0 && addr_err)
      ExcCode_MEM = is_ld ? EXC_ADEL : EXC_ADES;
  end

  assign dm.DM_Addr = {a[31:2], 2'b00};
  assign dm.DM_WE   = is_st && ExcCode_MEM == 5'd0;

  always_comb begin
    dm.DM_BE    = 4'b0000;
    dm.DM_WData = data_q;
    unique case (1'b1)
      is_sw: dm.DM_BE = 4'b1111;
      is_sh: begin
        dm.DM_BE    = a[1] ? 4'b1100 : 4'b0011;
        dm.DM_WData = {2{data_q[15:0]}};
      end
      is_sb: begin
        dm.DM_BE    = 4'b0001 << a[1:0];
        dm.DM_WData = {4{data_q[7:0]}};
      end
      default: ;
    endcase
  end

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    unique case (a[1:0])
      2'd0: rbyte = dm.DM_RData[7:0];
      2'd1: rbyte = dm.DM_RData[15:8];
      2'd2: rbyte = dm.DM_RData[23:16];
      default: rbyte = dm.DM_RData[31:24];
    endcase
  end

  assign rhalf = a[1] ? dm.DM_RData[31:16] : dm.DM_RData[15:0];

  always_comb begin
    LoadData_MEM = 32'd0;
    unique case (1'b1)
      is_lw:  LoadData_MEM = dm.DM_RData;
      is_lb:  LoadData_MEM = {{24{rbyte[7]}}, rbyte};
      is_lbu: LoadData_MEM = {24'd0, rbyte};
      is_lh:  LoadData_MEM = {{16{rhalf[15]}}, rhalf};
      is_lhu: LoadData_MEM = {16'd0, rhalf};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan steps then random traffic
// compared against a behavioural model of the EX/MEM register and memory rules.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, flush, stall;
  logic [31:0] Instr_EX, PC_EX, ALUout_EX, ForwardToDM_EX;
  logic        Overflow_EX;
  logic [4:0]  RegA3_EX, ExcCode_EX;
  logic [31:0] Instr_MEM, PC_MEM, ALUout_MEM, LoadData_MEM;
  logic [4:0]  RegA3_MEM, ExcCode_MEM;

  mem_stage_if bus ();

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .Instr_EX(Instr_EX), .PC_EX(PC_EX), .ALUout_EX(ALUout_EX),
    .Overflow_EX(Overflow_EX), .RegA3_EX(RegA3_EX),
    .ForwardToDM_EX(ForwardToDM_EX), .ExcCode_EX(ExcCode_EX),
    .Instr_MEM(Instr_MEM), .PC_MEM(PC_MEM), .ALUout_MEM(ALUout_MEM),
    .RegA3_MEM(RegA3_MEM), .LoadData_MEM(LoadData_MEM),
    .ExcCode_MEM(ExcCode_MEM), .dm(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model of the pipeline register contents.
  logic [31:0] m_instr, m_pc, m_alu, m_data;
  logic [4:0]  m_a3, m_exc;

  // Access size in bytes (0 = not a memory op), load/store/signedness.
  function automatic int acc_size(input logic [5:0] op);
    case (op)
      6'h23, 6'h2B: return 4;
      6'h21, 6'h25, 6'h29: return 2;
      6'h20, 6'h24, 6'h28: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic bit is_load(input logic [5:0] op);
    return op inside {6'h23, 6'h20, 6'h24, 6'h21, 6'h25};
  endfunction
  function automatic bit is_store(input logic [5:0] op);
    return op inside {6'h2B, 6'h28, 6'h29};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [5:0] op, input logic [31:0] alu,
                        input logic [31:0] data, input logic ovf,
                        input logic [4:0] exc);
    Instr_EX       = {op, 26'($urandom)};
    PC_EX          = 32'h0000_3000 + ($urandom_range(0, 255) << 2);
    ALUout_EX      = alu;
    ForwardToDM_EX = data;
    Overflow_EX    = ovf;
    RegA3_EX       = 5'($urandom);
    ExcCode_EX     = exc;
  endtask

  task automatic cycle(input logic r, input logic f, input logic s);
    logic [5:0] op;
    reset = r; flush = f; stall = s;
    op = Instr_EX[31:26];
    if (r || f) begin
      m_instr = 0; m_pc = 0; m_alu = 0; m_a3 = 0; m_data = 0; m_exc = 0;
    end else if (!s) begin
      m_instr = Instr_EX; m_pc = PC_EX; m_alu = ALUout_EX;
      m_a3 = RegA3_EX; m_data = ForwardToDM_EX;
      m_exc = ExcCode_EX;
      if (Overflow_EX && is_load(op)) m_exc = 5'd4;
      if (Overflow_EX && is_store(op)) m_exc = 5'd5;
    end
    @(posedge clk);
    #1;
    reset = 0; flush = 0; stall = 0;
  endtask

  // Expected outputs derived from the model fields with plain arithmetic.
  task automatic check_all(input string tag);
    logic [5:0]  op;
    int          sz, off, sh;
    logic [31:0] a, mask, val, exp_be, exp_wd;
    logic [4:0]  exc;
    bit          err, in_dm, in_tc;
    op  = m_instr[31:26];
    sz  = acc_size(op);
    a   = m_alu;
    off = a % 4;
    err = 0;
    if (sz != 0) begin
      in_dm = a <= 32'h2FFF;
      in_tc = (a >= 32'h7F00 && a - 32'h7F00 < 12)
           || (a >= 32'h7F10 && a - 32'h7F10 < 12);
      if (a % sz != 0) err = 1;
      if (!in_dm && !in_tc) err = 1;
      if (in_tc && sz != 4) err = 1;
      if (is_store(op) && (a == 32'h7F08 || a == 32'h7F18)) err = 1;
    end
    if (m_exc != 0) exc = m_exc;
    else if (err) exc = is_load(op) ? 5'd4 : 5'd5;
    else exc = 0;
    sh = off - (sz == 0 ? 0 : off % sz);
    chk({tag, ":instr"}, Instr_MEM, m_instr);
    chk({tag, ":pc"}, PC_MEM, m_pc);
    chk({tag, ":alu"}, ALUout_MEM, m_alu);
    chk({tag, ":a3"}, 32'(RegA3_MEM), 32'(m_a3));
    chk({tag, ":exc"}, 32'(ExcCode_MEM), 32'(exc));
    chk({tag, ":addr"}, bus.DM_Addr, a - off);
    chk({tag, ":we"}, 32'(bus.DM_WE), 32'(is_store(op) && exc == 0));
    if (is_store(op)) begin
      mask   = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
      exp_wd = (sz == 4) ? m_data : (sz == 2) ? (m_data & mask) * 32'h0001_0001
                                              : (m_data & mask) * 32'h0101_0101;
      exp_be = ((32'd1 << sz) - 1) << sh;
      chk({tag, ":wdata"}, bus.DM_WData, exp_wd);
      if (exc == 0) chk({tag, ":be"}, 32'(bus.DM_BE), exp_be);
    end else begin
      chk({tag, ":be"}, 32'(bus.DM_BE), 32'd0);
    end
    if (is_load(op)) begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
      val  = (bus.DM_RData >> (8 * sh)) & mask;
      if ((op == 6'h20 || op == 6'h21) && val[8 * sz - 1]) val = val | ~mask;
      chk({tag, ":ld"}, LoadData_MEM, val);
    end else begin
      chk({tag, ":ld"}, LoadData_MEM, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return $urandom_range(0, 32'h2FFF);
      1: return 32'h2FF0 + $urandom_range(0, 31);
      2: return 32'h7F00 + $urandom_range(0, 15);
      3: return 32'h7F10 + $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [10] = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25,
                             6'h2B, 6'h28, 6'h29, 6'h00, 6'h08};
    return ops[$urandom_range(0, 9)];
  endfunction

  initial begin
    reset = 1; flush = 0; stall = 0;
    bus.DM_RData = 32'h0;
    set_ex(6'h00, 0, 0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check_all("reset");
    chk("reset_instr", Instr_MEM, 32'd0);

    set_ex(6'h2B, 32'h10, 32'h1122_3344, 0, 0);
    cycle(0, 0, 0);
    check_all("sw");
    chk("sw_be", 32'(bus.DM_BE), 32'hF);
    chk("sw_wdata", bus.DM_WData, 32'h1122_3344);

    set_ex(6'h28, 32'h13, 32'h0000_00A5, 0, 0);
    cycle(0, 0, 0);
    check_all("sb");
    chk("sb_be", 32'(bus.DM_BE), 32'h8);
    chk("sb_wdata", bus.DM_WData, 32'hA5A5_A5A5);

    bus.DM_RData = 32'h8012_3456;
    set_ex(6'h20, 32'h13, 0, 0, 0);
    cycle(0, 0, 0);
    check_all("lb");
    chk("lb_val", LoadData_MEM, 32'hFFFF_FF80);
    set_ex(6'h24, 32'h13, 0, 0, 0);
    cycle(0, 0, 0);
    chk("lbu_val", LoadData_MEM, 32'h0000_0080);

    set_ex(6'h23, 32'h6, 0, 0, 0);
    cycle(0, 0, 0);
    check_all("lw_mis");
    chk("lw_mis_exc", 32'(ExcCode_MEM), 32'd4);
    set_ex(6'h29, 32'h7F08, 32'h55, 0, 0);
    cycle(0, 0, 0);
    chk("sh_tc_exc", 32'(ExcCode_MEM), 32'd5);
    chk("sh_tc_we", 32'(bus.DM_WE), 32'd0);
    set_ex(6'h2B, 32'h7F08, 32'h55, 0, 0);
    cycle(0, 0, 0);
    chk("sw_cnt_exc", 32'(ExcCode_MEM), 32'd5);
    set_ex(6'h2B, 32'h7F04, 32'h55, 0, 0);
    cycle(0, 0, 0);
    chk("sw_tc_we", 32'(bus.DM_WE), 32'd1);

    set_ex(6'h23, 32'h10, 0, 1, 0);
    cycle(0, 0, 0);
    chk("ovf_ld", 32'(ExcCode_MEM), 32'd4);
    set_ex(6'h2B, 32'h10, 0, 1, 5'd12);
    cycle(0, 0, 0);
    chk("ovf_st", 32'(ExcCode_MEM), 32'd5);
    chk("ovf_st_we", 32'(bus.DM_WE), 32'd0);
    set_ex(6'h00, 32'h10, 0, 1, 5'd12);
    cycle(0, 0, 0);
    chk("add_exc", 32'(ExcCode_MEM), 32'd12);

    set_ex(6'h2B, 32'h20, 32'hCAFE_F00D, 0, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_ex(rand_op(), rand_addr(), $urandom, 0, 0);
      cycle(0, 0, 1);
      check_all("stall");
      chk("stall_alu", ALUout_MEM, 32'h20);
    end
    set_ex(6'h2B, 32'h40, 32'h1, 0, 0);
    cycle(0, 1, 1);
    check_all("flush_stall");
    chk("fs_instr", Instr_MEM, 32'd0);
    chk("fs_we", 32'(bus.DM_WE), 32'd0);

    set_ex(6'h2B, 32'h44, 32'h77, 0, 0);
    cycle(1, 0, 1);
    chk("rst_instr", Instr_MEM, 32'd0);
    chk("rst_we", 32'(bus.DM_WE), 32'd0);
    cycle(0, 0, 0);
    check_all("post_rst");
    chk("post_rst_alu", ALUout_MEM, 32'h44);

    for (int i = 0; i < 400; i++) begin
      logic r, f, s;
      set_ex(rand_op(), rand_addr(), $urandom,
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0) ? 5'd12 : 5'd0);
      r = ($urandom_range(0, 40) == 0);
      f = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 7) == 0);
      cycle(r, f, s);
      bus.DM_RData = $urandom;
      #1;
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage MIPS CPU, directly downstream of the EX stage.
- Contains the EX/MEM pipeline register, which latches ALU result, destination register, store data, PC, instruction and exception code.
- Drives the data-memory/bridge write port: address, byte enables, write data.
- Detects address exceptions (AdEL=4, AdES=5) and extends load data for the WB stage.

Parameters:
- DM_TOP, 32'h0000_2FFF, last valid data-memory byte address; DM starts at 0.
- TC0_BASE, 32'h0000_7F00, timer0 register window base; 12 bytes.
- TC1_BASE, 32'h0000_7F10, timer1 register window base; 12 bytes.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- flush  input  1  exception/eret flush: load bubble into EX/MEM
- stall  input  1  hold EX/MEM contents
- Instr_EX  input  32  instruction leaving EX
- PC_EX  input  32  PC of that instruction
- ALUout_EX  input  32  ALU/multdiv result (effective address for loads/stores)
- Overflow_EX  input  1  raw ALU overflow flag
- RegA3_EX  input  5  destination register
- ForwardToDM_EX  input  32  forwarded rt value (store data)
- ExcCode_EX  input  5  exception code so far (0 = none)
- DM_RData  input  32  word read from DM/bridge at DM_Addr
- Instr_MEM  output  32  registered instruction
- PC_MEM  output  32  registered PC
- ALUout_MEM  output  32  registered result
- RegA3_MEM  output  5  registered destination register
- DM_Addr  output  32  {ALUout_MEM[31:2],2'b00}
- DM_WData  output  32  store data, lane-replicated
- DM_BE  output  4  byte enables
- DM_WE  output  1  write strobe
- LoadData_MEM  output  32  aligned, extended load result
- ExcCode_MEM  output  5  final exception code for CP0

Behaviour:
- Register update, rising clk, in priority order:
  - reset: all registered fields are 0 (Instr=nop, ExcCode=0).
  - flush: same as reset.
  - stall: hold.
  - otherwise: capture the *_EX inputs.
  - The exception-code conversion is applied at capture. If Overflow_EX=1 and Instr_EX is a load, store 4. If Overflow_EX=1 and it is a store, store 5. Otherwise store ExcCode_EX.
- Decode (combinational from Instr_MEM[31:26]):
  - loads: lw 23, lb 20, lbu 24, lh 21, lhu 25.
  - stores: sw 2B, sb 28, sh 29.
- Address checks (combinational on ALUout_MEM, only when the registered ExcCode is 0):
  - Misalignment: word access with A[1:0]≠0; half access with A[0]≠0.
  - Out of range: A not in [0,DM_TOP] and not in either timer window.
  - Timer window restrictions:
    - Byte/half access to a timer window is an error.
    - A store to timer offset 8 (count register, read-only) is an error.
  - Result: a load error gives ExcCode_MEM=4, a store error gives 5. Otherwise ExcCode_MEM is the registered code.
- Registered code ≠0 always wins; no re-encoding.
- Write port:
  - DM_WE = store & ExcCode_MEM==0. Flush effect is visible because a flushed register holds nop.
  - DM_BE:
    - sw: 1111.
    - sh: 0011 if A[1]=0, else 1100.
    - sb: one-hot 1<<A[1:0].
    - non-store: 0000.
  - DM_WData:
    - sw: data.
    - sh: {2{data[15:0]}}.
    - sb: {4{data[7:0]}}.
- Load extension: select byte/half by A[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through. Non-loads give 0.
- Zero-latency combinational read: DM_RData must be valid in the same cycle as DM_Addr.
- Simultaneous flush+stall: flush wins. Reset mid-stall: reset wins.

Test Plan:
- sw $t,0x10 with data 0x11223344, no exception -> DM_WE=1, DM_BE=1111, DM_Addr=0x10, DM_WData=0x11223344, ExcCode_MEM=0.
- sb to addr 0x13, data 0x000000A5 -> DM_BE=1000, DM_WData=0xA5A5A5A5. lb from 0x13 with DM_RData=0x80xxxxxx -> LoadData_MEM=0xFFFFFF80; lbu gives 0x00000080.
- lw from 0x6 -> ExcCode_MEM=4, DM_WE=0. sh to 0x7F08 -> ExcCode_MEM=5, DM_BE irrelevant, DM_WE=0. sw to 0x7F08 -> 5. sw to 0x7F04 -> DM_WE=1.
- Load with Overflow_EX=1 -> captured ExcCode 4. Store with Overflow_EX=1 and ExcCode_EX=12 -> captured 5. Add with ExcCode_EX=12 -> 12 retained.
- stall=1 for 3 cycles with changing EX inputs -> outputs frozen. Assert flush+stall together -> next cycle Instr_MEM=0, DM_WE=0, ExcCode_MEM=0.
- reset=1 during a pending sw -> next edge all outputs 0, DM_WE=0. Deassert -> the pipeline captures normally on the following edge.
